// File: rtl/rnn_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rnn_mem_arbiter
// Purpose  : Arbitrates the shared parameter/result memory port between the
//            host loader and the RNN core. The host loads data over req/ack.
//            A run request pulses core_ready. The core then owns the port
//            exclusively until core_busy falls. A start timeout sets a sticky
//            error flag.
// Revision : 1.0 - initial release
// ============================================================================
module rnn_mem_arbiter #(
  parameter int AW       = 17,
  parameter int DW       = 20,
  parameter int SW       = 3,
  parameter int HOST_MAX = 64,
  parameter int START_TO = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_req,
  output logic             run_done,
  output logic             run_err,
  input  logic             host_req,
  input  logic [SW-1:0]    host_msel,
  input  logic [AW-1:0]    host_maddr,
  input  logic [DW-1:0]    host_wdata,
  output logic             host_ack,
  output logic             host_rvalid,
  output logic [DW-1:0]    host_rdata,
  output logic [CNT_W-1:0] host_wait_cnt,
  output logic             core_ready,
  input  logic             core_busy,
  input  logic             core_mce,
  input  logic [SW-1:0]    core_msel,
  input  logic [AW-1:0]    core_maddr,
  input  logic [DW-1:0]    core_mdata_w,
  output logic [DW-1:0]    core_mdata_r,
  output logic             mem_ce,
  output logic [SW-1:0]    mem_msel,
  output logic [AW-1:0]    mem_maddr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  output logic [1:0]       arb_state
);

  localparam logic [SW-1:0] c_MSEL_WRITE = SW'(3'b101);
  localparam logic [SW-1:0] c_MSEL_IDLE  = SW'(3'b100);
  localparam int            c_BW         = $clog2(HOST_MAX + 1);
  localparam int            c_TW         = $clog2(START_TO + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOST  = 2'd1,
    ST_START = 2'd2,
    ST_CORE  = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_core_ready;
  logic             r_err;
  logic             r_run_prio;   // a forced burst exit lets the run win the next IDLE
  logic [c_BW-1:0]  r_burst;
  logic [c_TW-1:0]  r_tmo;        // cycles since the core_ready pulse
  logic             r_seen_busy;
  logic             r_busy_d;
  logic             r_rvalid;
  logic [CNT_W-1:0] r_wait;

  logic w_host_ack;
  logic w_burst_hit;
  logic w_run_fall;

  assign w_host_ack  = (r_state == ST_HOST) && host_req;
  assign w_burst_hit = w_host_ack && ((int'(r_burst) + 1) >= HOST_MAX);
  assign w_run_fall  = (r_state == ST_CORE) && r_busy_d && !core_busy;

  assign host_ack      = w_host_ack;
  assign host_rvalid   = r_rvalid;
  assign host_rdata    = r_rvalid ? mem_rdata : '0;
  assign host_wait_cnt = r_wait;
  assign core_ready    = r_core_ready;
  assign core_mdata_r  = mem_rdata;
  assign run_done      = w_run_fall;
  assign run_err       = r_err;
  assign arb_state     = r_state;

  // Arbitration state machine with registered start pulse and error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_core_ready <= 1'b0;
      r_err        <= 1'b0;
      r_run_prio   <= 1'b0;
      r_burst      <= '0;
      r_tmo        <= '0;
      r_seen_busy  <= 1'b0;
    end else begin
      r_core_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_burst <= '0;
          if (host_req && !(r_run_prio && run_req)) begin
            r_state    <= ST_HOST;
            r_run_prio <= 1'b0;
          end else if (run_req) begin
            r_state      <= ST_START;
            r_core_ready <= 1'b1;
            r_run_prio   <= 1'b0;
          end
        end
        ST_HOST: begin
          if (w_host_ack && (int'(r_burst) < HOST_MAX)) begin
            r_burst <= r_burst + c_BW'(1);
          end
          if (!host_req) begin
            r_state <= ST_IDLE;
            r_burst <= '0;
          end else if (run_req && w_burst_hit) begin
            r_state    <= ST_IDLE;
            r_burst    <= '0;
            r_run_prio <= 1'b1;
          end
        end
        ST_START: begin
          r_state     <= ST_CORE;
          r_tmo       <= c_TW'(1);
          r_seen_busy <= 1'b0;
        end
        ST_CORE: begin
          if (core_busy) begin
            r_seen_busy <= 1'b1;
          end
          if (int'(r_tmo) < START_TO) begin
            r_tmo <= r_tmo + c_TW'(1);
          end
          if (w_run_fall) begin
            r_state <= ST_IDLE;
          end else if (!r_seen_busy && !core_busy && (int'(r_tmo) >= START_TO)) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Delayed core_busy for falling-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy_d <= 1'b0;
    end else begin
      r_busy_d <= core_busy;
    end
  end

  // Read-data valid follows an acked non-write host access by one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_host_ack && (host_msel != c_MSEL_WRITE);
    end
  end

  // Saturating count of cycles the host waits without an ack
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait <= '0;
    end else if (w_host_ack) begin
      r_wait <= '0;
    end else if (host_req && (r_wait != {CNT_W{1'b1}})) begin
      r_wait <= r_wait + CNT_W'(1);
    end
  end

  // Memory port mux: host or core fields pass straight through; idle otherwise
  always_comb begin
    mem_ce    = 1'b0;
    mem_msel  = c_MSEL_IDLE;
    mem_maddr = '0;
    mem_wdata = '0;
    case (r_state)
      ST_HOST: begin
        mem_ce    = host_req;
        mem_msel  = host_msel;
        mem_maddr = host_maddr;
        mem_wdata = host_wdata;
      end
      ST_CORE: begin
        mem_ce    = core_mce;
        mem_msel  = core_msel;
        mem_maddr = core_maddr;
        mem_wdata = core_mdata_w;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_rnn_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rnn_mem_arbiter
// Purpose  : Directed bench for rnn_mem_arbiter with a behavioural model,
//            a stub core and a pattern memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rnn_mem_arbiter;

  localparam int AW = 17, DW = 20, SW = 3, HOST_MAX = 64, START_TO = 4, CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             run_req, run_done, run_err;
  logic             host_req, host_ack, host_rvalid;
  logic [SW-1:0]    host_msel;
  logic [AW-1:0]    host_maddr;
  logic [DW-1:0]    host_wdata, host_rdata;
  logic [CNT_W-1:0] host_wait_cnt;
  logic             core_ready, core_busy, core_mce;
  logic [SW-1:0]    core_msel;
  logic [AW-1:0]    core_maddr;
  logic [DW-1:0]    core_mdata_w, core_mdata_r;
  logic             mem_ce;
  logic [SW-1:0]    mem_msel;
  logic [AW-1:0]    mem_maddr;
  logic [DW-1:0]    mem_wdata, mem_rdata;
  logic [1:0]       arb_state;

  int n_vec = 0;
  int n_mis = 0;
  int ready_cnt = 0;
  int done_cnt = 0;
  int stub_mode = 0;   // 0: busy 100 cycles, 1: never busy, 2: busy until reset

  rnn_mem_arbiter #(
    .AW(AW), .DW(DW), .SW(SW), .HOST_MAX(HOST_MAX), .START_TO(START_TO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .run_req(run_req), .run_done(run_done), .run_err(run_err),
    .host_req(host_req), .host_msel(host_msel), .host_maddr(host_maddr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .host_wait_cnt(host_wait_cnt),
    .core_ready(core_ready), .core_busy(core_busy), .core_mce(core_mce),
    .core_msel(core_msel), .core_maddr(core_maddr), .core_mdata_w(core_mdata_w),
    .core_mdata_r(core_mdata_r),
    .mem_ce(mem_ce), .mem_msel(mem_msel), .mem_maddr(mem_maddr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .arb_state(arb_state)
  );

  always #5 clk = ~clk;

  // Pattern memory: address 5 holds 0ABCD, everything else is address-derived
  function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
    if (a == AW'(5)) return 20'h0ABCD;
    return DW'(a) ^ 20'h5A5A5;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) mem_rdata <= '0;
    else if (mem_ce && mem_msel != 3'b101) mem_rdata <= rd_fn(mem_maddr);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Behavioural model and per-cycle compare at the falling edge
  int               m_state, m_acks, m_since;
  logic             m_prio, m_seen, m_prev_busy, m_err, m_rvalid;
  logic [DW-1:0]    m_rdata;
  int               m_wait;
  logic             e_ack, e_ce, e_done;
  logic [SW-1:0]    e_msel;
  logic [AW-1:0]    e_addr;
  logic [DW-1:0]    e_wd;

  initial begin : model
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_state = 0; m_acks = 0; m_since = 0; m_prio = 0; m_seen = 0;
        m_prev_busy = 0; m_err = 0; m_rvalid = 0; m_rdata = '0; m_wait = 0;
      end
      e_ack = (m_state == 1) && host_req;
      e_done = (m_state == 3) && m_prev_busy && !core_busy;
      e_ce = 1'b0; e_msel = 3'b100; e_addr = '0; e_wd = '0;
      if (m_state == 1) begin
        e_ce = host_req; e_msel = host_msel; e_addr = host_maddr; e_wd = host_wdata;
      end else if (m_state == 3) begin
        e_ce = core_mce; e_msel = core_msel; e_addr = core_maddr; e_wd = core_mdata_w;
      end
      chk("arb_state", 32'(arb_state), m_state);
      chk("host_ack", 32'(host_ack), 32'(e_ack));
      chk("core_ready", 32'(core_ready), 32'(m_state == 2));
      chk("run_done", 32'(run_done), 32'(e_done));
      chk("run_err", 32'(run_err), 32'(m_err));
      chk("host_rvalid", 32'(host_rvalid), 32'(m_rvalid));
      chk("host_rdata", 32'(host_rdata), m_rvalid ? 32'(m_rdata) : 32'd0);
      chk("host_wait_cnt", 32'(host_wait_cnt), m_wait);
      chk("mem_ce", 32'(mem_ce), 32'(e_ce));
      chk("mem_msel", 32'(mem_msel), 32'(e_msel));
      chk("mem_maddr", 32'(mem_maddr), 32'(e_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
      chk("core_mdata_r", 32'(core_mdata_r), 32'(mem_rdata));
      if (core_ready) ready_cnt++;
      if (run_done) done_cnt++;
      if (reset) begin
        // next-cycle behaviour from the current inputs
        m_rvalid = e_ack && (host_msel != 3'b101);
        if (m_rvalid) m_rdata = rd_fn(host_maddr);
        if (e_ack) m_wait = 0;
        else if (host_req && m_wait < 65535) m_wait++;
        case (m_state)
          0: begin
            m_acks = 0;
            if (host_req && !(m_prio && run_req)) begin m_state = 1; m_prio = 0; end
            else if (run_req) begin m_state = 2; m_prio = 0; end
          end
          1: begin
            if (e_ack) m_acks++;
            if (!host_req) m_state = 0;
            else if (run_req && m_acks >= HOST_MAX) begin m_state = 0; m_prio = 1; end
          end
          2: begin m_state = 3; m_since = 1; m_seen = 0; end
          default: begin
            if (e_done) m_state = 0;
            else if (!m_seen && !core_busy && m_since >= START_TO) begin m_err = 1; m_state = 0; end
            if (core_busy) m_seen = 1;
            m_since++;
          end
        endcase
        m_prev_busy = core_busy;
      end
    end
  end

  // Stub RNN core reacting to core_ready
  initial begin : core_stub
    core_busy = 0; core_mce = 0; core_msel = '0; core_maddr = '0; core_mdata_w = '0;
    forever begin
      @(negedge clk);
      if (core_ready && reset && stub_mode != 1) begin
        @(posedge clk); #1;
        core_busy = 1; core_mce = 1;
        if (stub_mode == 0) begin
          for (int i = 0; i < 100 && reset; i++) begin
            core_maddr = AW'(i);
            core_msel = i[0] ? 3'b101 : 3'b000;
            core_mdata_w = DW'(i * 3);
            @(posedge clk); #1;
          end
        end else begin
          while (reset) begin
            @(posedge clk or negedge reset);
            if (reset) #1;
          end
        end
        core_busy = 0; core_mce = 0;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int n, acks;
    reset = 0; run_req = 0; host_req = 0; host_msel = '0; host_maddr = '0; host_wdata = '0;
    repeat (3) tick();
    chk("reset_state", 32'(arb_state), 0);
    chk("reset_bus_msel", 32'(mem_msel), 32'h4);
    chk("reset_ack", 32'(host_ack), 0);
    reset = 1;

    // three host writes: acks on cycles 1..3
    host_req = 1; host_msel = 3'b101; host_maddr = '0; host_wdata = 20'h11111;
    for (int k = 0; k < 3; k++) begin
      tick();
      host_maddr = AW'(k); host_wdata = DW'(20'h11111 * (k + 1));
      #1;
      chk("wr_ack", 32'(host_ack), 1);
      chk("wr_msel", 32'(mem_msel), 32'h5);
      chk("wr_addr", 32'(mem_maddr), k);
    end
    tick(); host_req = 0; #1;
    chk("wr_end_ack", 32'(host_ack), 0);
    chk("wr_no_rvalid", 32'(host_rvalid), 0);

    // host read of address 5
    tick(); host_req = 1; host_msel = 3'b000; host_maddr = AW'(5); #1;
    tick(); #1;
    chk("rd_ack", 32'(host_ack), 1);
    tick(); host_req = 0; #1;
    chk("rd_rvalid", 32'(host_rvalid), 1);
    chk("rd_rdata", 32'(host_rdata), 32'h0ABCD);
    tick();

    // normal run with host held off
    stub_mode = 0; run_req = 1;
    tick(); run_req = 0; #1;
    chk("run_ready", 32'(core_ready), 1);
    chk("run_start_state", 32'(arb_state), 2);
    tick(); host_req = 1; host_msel = 3'b000; host_maddr = AW'(7); #1;
    chk("run_core_state", 32'(arb_state), 3);
    chk("run_held_ack", 32'(host_ack), 0);
    n = 1;
    while (!run_done && n < 300) begin tick(); #1; n++; end
    chk("run_done_offset", n, 101);
    chk("run_wait_at_done", 32'(host_wait_cnt), 100);
    tick(); #1;
    chk("post_run_idle", 32'(arb_state), 0);
    chk("post_run_ack", 32'(host_ack), 0);
    tick(); #1;
    chk("first_ack_after", 32'(host_ack), 1);
    chk("wait_run_len", 32'(host_wait_cnt), 102);
    tick(); host_req = 0;
    tick(); tick(); #1;
    chk("ready_pulses", ready_cnt, 1);
    chk("done_pulses", done_cnt, 1);

    // start timeout
    stub_mode = 1; run_req = 1;
    tick(); run_req = 0; #1;
    chk("to_ready", 32'(core_ready), 1);
    repeat (4) begin tick(); #1; end
    chk("to_err_before", 32'(run_err), 0);
    chk("to_state_before", 32'(arb_state), 3);
    tick(); #1;
    chk("to_err", 32'(run_err), 1);
    chk("to_state_idle", 32'(arb_state), 0);
    repeat (3) begin tick(); #1; end
    chk("to_err_sticky", 32'(run_err), 1);
    chk("to_no_done", done_cnt, 1);

    // host burst limit with pending run, then reset mid-CORE
    stub_mode = 2; host_req = 1; host_msel = 3'b101; host_maddr = AW'(9); run_req = 1;
    n = 0; acks = 0;
    while (arb_state != 2'd2 && n < 200) begin
      tick(); #1; n++;
      if (host_ack) acks++;
    end
    run_req = 0;
    chk("burst_acks", acks, 64);
    chk("burst_to_start", n, 66);
    tick(); #1;
    chk("burst_core_state", 32'(arb_state), 3);
    tick(); tick();
    reset = 0; #1;
    chk("rst_bus_ce", 32'(mem_ce), 0);
    chk("rst_bus_msel", 32'(mem_msel), 32'h4);
    chk("rst_bus_addr", 32'(mem_maddr), 0);
    chk("rst_state", 32'(arb_state), 0);
    chk("rst_err_clear", 32'(run_err), 0);
    host_req = 0;
    tick(); tick(); reset = 1;
    repeat (3) begin tick(); #1; end
    chk("rst_no_done", done_cnt, 1);
    chk("rst_idle", 32'(arb_state), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
